// File: rtl/alu_pkg.sv
// Shared ALU constants: operand width and opcode encodings.
package alu_pkg;
    localparam int XLEN = 32;
    localparam int OPW  = 4;

    localparam logic [OPW-1:0] ALU_AND    = 4'b0000;
    localparam logic [OPW-1:0] ALU_OR     = 4'b0001;
    localparam logic [OPW-1:0] ALU_ADD    = 4'b0010;
    localparam logic [OPW-1:0] ALU_XOR    = 4'b0011;
    localparam logic [OPW-1:0] ALU_SLL    = 4'b0100;
    localparam logic [OPW-1:0] ALU_SRL    = 4'b0101;
    localparam logic [OPW-1:0] ALU_SUB    = 4'b0110;
    localparam logic [OPW-1:0] ALU_SLT    = 4'b0111;
    localparam logic [OPW-1:0] ALU_SLTU   = 4'b1000;
    localparam logic [OPW-1:0] ALU_OP_MAX = 4'b1000;
endpackage

// File: rtl/alu.sv
// Combinational integer ALU; unknown opcodes yield zero.
module alu
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [OPW-1:0]  alu_op,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    always_comb begin
        result = '0;
        case (alu_op)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SRL:  result = a >> b[4:0];
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters,
// with a single registered response slot.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN_P = XLEN,
    parameter int OPW_P  = OPW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [XLEN_P-1:0] req0_a,
    input  logic [XLEN_P-1:0] req0_b,
    input  logic [OPW_P-1:0]  req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [XLEN_P-1:0] req1_a,
    input  logic [XLEN_P-1:0] req1_b,
    input  logic [OPW_P-1:0]  req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [XLEN_P-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic              busy
);
    logic              full_q, full_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [XLEN_P-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;

    logic              grant0, grant1, slot_free, owner_rdy, accept;
    logic [XLEN_P-1:0] alu_a, alu_b, alu_res;
    logic [OPW_P-1:0]  alu_op;
    logic              alu_zero, op_err;

    // On a tie the requester that did not win last time goes first.
    assign grant0 = req0_valid && (!req1_valid || last_q);
    assign grant1 = req1_valid && (!req0_valid || !last_q);

    assign owner_rdy = owner_q ? rsp1_ready : rsp0_ready;
    assign slot_free = !full_q || owner_rdy;

    assign req0_ready = grant0 && slot_free;
    assign req1_ready = grant1 && slot_free;
    assign accept     = req0_ready || req1_ready;

    assign alu_a  = grant1 ? req1_a  : req0_a;
    assign alu_b  = grant1 ? req1_b  : req0_b;
    assign alu_op = grant1 ? req1_op : req0_op;
    assign op_err = (alu_op > ALU_OP_MAX);

    alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .alu_op (alu_op),
        .result (alu_res),
        .zero   (alu_zero)
    );

    always_comb begin
        full_d   = full_q;
        owner_d  = owner_q;
        last_d   = last_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
        if (accept) begin
            full_d   = 1'b1;
            owner_d  = grant1;
            last_d   = grant1;
            result_d = alu_res;
            zero_d   = alu_zero;
            err_d    = op_err;
        end else if (full_q && owner_rdy) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= 1'b0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            full_q   <= full_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign rsp0_valid = full_q && !owner_q;
    assign rsp1_valid = full_q && owner_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign busy       = full_q;
endmodule
